// File: rtl/vme_bus_master.sv
// -----------------------------------------------------------------------------
// vme_bus_master
// Requester end of a VME A24/D8 data-transfer bus. Accepts one local byte
// request at a time, requests the bus on a single BR level, takes the grant
// from the BGIN daisy chain, asserts BBSY and runs one A24 byte cycle
// (AS/DS0 handshake against DTACK/BERR with a local timeout). The read data or
// an error is returned to the local side as a one-cycle response pulse.
//
// Ports
//   i_clock / i_reset        system clock, asynchronous active-low reset
//   i_req_*  / o_req_ready   local request handshake (accept = valid & ready)
//   o_resp_*                 response pulse, read data and error flag
//   o_vme_br, i_vme_bgin,
//   o_vme_bgout, io_vme_bbsy,
//   i_vme_bclr               arbitration signals (active low, BBSY open-drain)
//   o_vme_address_strobe, o_vme_data_strobe, o_vme_lword, o_vme_write,
//   o_vme_address_mod, o_vme_address, io_vme_data
//                            DTB signals, high-Z whenever the bus is not owned
//   i_vme_dtack, i_vme_berr  slave acknowledge / bus error (active low)
// -----------------------------------------------------------------------------
module vme_bus_master #(
  parameter int unsigned BR_LEVEL = 0,
  parameter logic [5:0]  ADDR_MOD = 6'h39,
  parameter int unsigned TIMEOUT  = 255,
  parameter bit          HOLD_BUS = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [23:0] i_req_address,
  input  logic [7:0]  i_req_data,
  output logic        o_resp_valid,
  output logic [7:0]  o_resp_data,
  output logic        o_resp_error,
  output logic [3:0]  o_vme_br,
  input  logic [3:0]  i_vme_bgin,
  output logic [3:0]  o_vme_bgout,
  inout  wire         io_vme_bbsy,
  input  logic        i_vme_bclr,
  output logic        o_vme_address_strobe,
  output logic [1:0]  o_vme_data_strobe,
  output logic        o_vme_lword,
  output logic        o_vme_write,
  output logic [5:0]  o_vme_address_mod,
  output logic [23:0] o_vme_address,
  inout  wire  [7:0]  io_vme_data,
  input  logic        i_vme_dtack,
  input  logic        i_vme_berr
);

  localparam logic [1:0] BR_IDX      = 2'(BR_LEVEL);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQUEST  = 3'd1,
    ST_ADDRESS  = 3'd2,
    ST_STROBE   = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_RELEASE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_write;
  logic [23:0] r_address;
  logic [7:0]  r_wdata;
  logic        r_stale;        // grant was already present when we raised BR
  logic [7:0]  r_count;
  logic        r_resp_valid;
  logic [7:0]  r_resp_data;
  logic        r_resp_error;

  logic        w_accept;
  logic        w_finish;
  logic        w_fail;
  logic        w_capture;
  logic        w_owner;
  logic        w_strobing;
  logic        w_hold_grant;
  logic        w_bbsy_free;
  logic [3:0]  w_bgout;
  logic [3:0]  w_br;

  // The bus is ours (BBSY asserted, DTB driven) from ADDRESS through RELEASE.
  assign w_owner    = (r_state == ST_ADDRESS) || (r_state == ST_STROBE) ||
                      (r_state == ST_WAIT_ACK) || (r_state == ST_RELEASE);
  assign w_strobing = (r_state == ST_STROBE) || (r_state == ST_WAIT_ACK);
  assign w_bbsy_free = (io_vme_bbsy == 1'b1);

  // A grant seen before our BR went out belongs to someone downstream, so it
  // keeps flowing until BGIN has been high once while we are requesting.
  assign w_hold_grant = (w_owner || (r_state == ST_REQUEST)) &&
                        !((r_state == ST_REQUEST) && r_stale);

  // Daisy chain pass-through; our level is blocked while we hold the grant.
  always_comb begin
    w_bgout = i_vme_bgin;
    if (w_hold_grant) begin
      w_bgout[BR_IDX] = 1'b1;
    end else begin
      w_bgout[BR_IDX] = i_vme_bgin[BR_IDX];
    end
  end

  // Bus request: only our level, only while waiting for the grant.
  always_comb begin
    w_br = 4'hF;
    if (r_state == ST_REQUEST) begin
      w_br[BR_IDX] = 1'b0;
    end else begin
      w_br[BR_IDX] = 1'b1;
    end
  end

  // Next-state logic and per-cycle event flags.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_fail       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_req_valid && i_reset) begin
          w_accept     = 1'b1;
          w_state_next = ST_REQUEST;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQUEST: begin
        if (!r_stale && !i_vme_bgin[BR_IDX] && w_bbsy_free) begin
          w_state_next = ST_ADDRESS;
        end else begin
          w_state_next = ST_REQUEST;
        end
      end
      ST_ADDRESS: begin
        w_state_next = ST_STROBE;
      end
      ST_STROBE: begin
        w_state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // BERR is checked first so it wins over a simultaneous DTACK.
        if (!i_vme_berr) begin
          w_finish     = 1'b1;
          w_fail       = 1'b1;
          w_state_next = ST_RELEASE;
        end else if (!i_vme_dtack) begin
          w_finish     = 1'b1;
          w_capture    = !r_write;
          w_state_next = ST_RELEASE;
        end else if (r_count == TIMEOUT_CNT) begin
          w_finish     = 1'b1;
          w_fail       = 1'b1;
          w_state_next = ST_RELEASE;
        end else begin
          w_state_next = ST_WAIT_ACK;
        end
      end
      ST_RELEASE: begin
        if (i_vme_dtack && i_vme_berr) begin
          if (HOLD_BUS && i_req_valid && i_vme_bclr) begin
            w_accept     = 1'b1;
            w_state_next = ST_ADDRESS;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_RELEASE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request latch, stale-grant tracking, timeout counter and response regs.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_write      <= 1'b0;
      r_address    <= 24'h000000;
      r_wdata      <= 8'h00;
      r_stale      <= 1'b0;
      r_count      <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 8'h00;
      r_resp_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write   <= i_req_write;
        r_address <= i_req_address;
        r_wdata   <= i_req_data;
      end

      if (w_accept && (r_state == ST_IDLE)) begin
        r_stale <= !i_vme_bgin[BR_IDX];
      end else if ((r_state == ST_REQUEST) && i_vme_bgin[BR_IDX]) begin
        r_stale <= 1'b0;
      end

      if (r_state == ST_STROBE) begin
        r_count <= 8'h00;
      end else if ((r_state == ST_WAIT_ACK) && (w_state_next == ST_WAIT_ACK)) begin
        r_count <= r_count + 8'd1;
      end

      r_resp_valid <= w_finish;
      if (w_finish) begin
        r_resp_error <= w_fail;
        r_resp_data  <= w_capture ? io_vme_data : 8'h00;
      end
    end
  end

  assign o_req_ready  = w_accept;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;
  assign o_resp_error = r_resp_error;
  assign o_vme_br     = w_br;
  assign o_vme_bgout  = w_bgout;

  // Everything below is released whenever the bus is not owned, so reset
  // frees the backplane on the same edge that clears the state register.
  assign io_vme_bbsy          = w_owner ? 1'b0 : 1'bz;
  assign o_vme_address_strobe = w_owner ? !w_strobing : 1'bz;
  assign o_vme_data_strobe    = w_owner ? (w_strobing ? 2'b10 : 2'b11) : 2'bzz;
  assign o_vme_lword          = w_owner ? 1'b1 : 1'bz;
  assign o_vme_write          = w_owner ? !r_write : 1'bz;
  assign o_vme_address_mod    = w_owner ? ADDR_MOD : 6'bzz_zzzz;
  assign o_vme_address        = w_owner ? r_address : 24'hzz_zzzz;
  assign io_vme_data          = (w_owner && r_write) ? r_wdata : 8'hzz;

endmodule
